acc_frame_gen: RTL and testbench
================================

// Module: acc_frame_gen
// PURPOSE
//  Frames a raw sample stream for the scalar accumulator: counts valid samples and
//  raises acc_done on the first word of each new accumulation window of acc_len samples.
//  Sits directly upstream of the accumulator; its outputs connect 1:1 to the accumulator's
//  din/din_valid/acc_done.
//  Also reports which accumulator dumps are complete windows versus restart partials.
// PARAMETERS
//  DIN_WIDTH        16  sample width, passed through unchanged
//  LEN_WIDTH        16  width of acc_len (max window = 2^LEN_WIDTH-1 samples)
//  FRAME_CNT_WIDTH  32  width of completed-frame counter, wraps modulo 2^FRAME_CNT_WIDTH
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous, active-high reset
//  din            in   DIN_WIDTH         sample in
//  din_valid      in   1                 sample qualifier
//  acc_len        in   LEN_WIDTH         samples per window; 0 treated as 1
//  sync_in        in   1                 restart framing; sample coincident with it opens a window
//  dout           out  DIN_WIDTH         registered din
//  dout_valid     out  1                 registered din_valid
//  acc_done       out  1                 high with dout_valid on first sample of a window
//  frame_complete out  1                 high with acc_done when the closing window was full-length
//  frame_count    out  FRAME_CNT_WIDTH   number of frame_complete pulses since reset
//  len_active     out  LEN_WIDTH         window length in force (after 0->1 mapping)
// BEHAVIOUR
//  - Reset: dout=0, dout_valid=0, acc_done=0, frame_complete=0, frame_count=0,
//    len_active=1, cnt=0, state=ARM. Reset mid-window discards the window; no pulse emitted.
//  - Latency: exactly 1 cycle din->dout; acc_done/frame_complete aligned to dout_valid.
//    acc_done and frame_complete are never high while dout_valid is low.
//  - State ARM: next sample opens a window, no prior window exists.
//    State RUN: cnt = samples already in current window (1..len_active).
//  - Per valid input sample, "boundary" = (state==ARM) | sync_in | (cnt==len_active):
//      boundary: acc_done=1; cnt<=1; len_active<=max(acc_len,1); state<=RUN;
//        frame_complete=1 only if state==RUN & ~sync_in & cnt==len_active.
//      else: acc_done=0; frame_complete=0; cnt<=cnt+1.
//  - Invalid cycles: no state change (gaps freeze cnt), except sync_in -> state<=ARM.
//  - acc_len sampled only at boundaries; mid-window changes take effect on next window.
//  - sync_in + valid + cnt==len_active: sync wins, frame_complete=0 (full window still
//    discarded downstream -- documented, deliberate).
//  - len_active==1: every valid sample has acc_done; frame_complete on all but the first.
//  - frame_count += 1 on each frame_complete; wraps to 0 silently.
//  - cnt is LEN_WIDTH bits; never exceeds len_active, so no overflow.
// STRUCTURE
//  - Shared header acc_defs.vh: default DIN_WIDTH/LEN_WIDTH/FRAME_CNT_WIDTH, state
//    encodings ARM=1'b0, RUN=1'b1, reused by accumulator wrappers.
//  - Flat: one input register stage, 2-state FSM, window counter, frame counter.
//    No sub-module; window counter is too small to justify one.
// TESTING
//  1 acc_len=4, din=0..11 continuous valid -> acc_done on din 0,4,8; frame_complete
//    on 4,8; frame_count=2; dout == din delayed 1 cycle.
//  2 acc_len=3, valid pattern 1,0,1,0,1,1 -> acc_done on 1st and 4th valid only;
//    frame_complete on 4th; cnt frozen during gaps.
//  3 acc_len=4, change to 2 after sample 1 -> next acc_done at sample 4, then 6,8;
//    len_active reads 4 until sample 4, then 2.
//  4 acc_len=5, sync_in with sample 2 -> acc_done at sample 2, frame_complete=0,
//    next acc_done at sample 7 with frame_complete=1.
//  5 acc_len=0 -> len_active=1, acc_done every valid sample, frame_count = samples-1.
//  6 rst high for 1 cycle after sample 2 of len=4 window -> all outputs 0 next cycle;
//    next valid gets acc_done=1, frame_complete=0, frame_count=0.
//  Bench pairs with the scalar accumulator: its dout_valid sums must equal reference
//  window sums on every frame_complete.

Source files
------------

// File: rtl/acc_frame_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_frame_gen_pkg
// Description : Shared defaults and FSM state encoding for the accumulator
//               framing logic and the wrappers that sit around it.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_frame_gen_pkg;

    // Default widths used by the framer and its bus interface
    localparam int c_DIN_WIDTH       = 16;
    localparam int c_LEN_WIDTH       = 16;
    localparam int c_FRAME_CNT_WIDTH = 32;

    // ARM: no window open yet, next valid sample opens one.
    // RUN: a window is open and being counted.
    typedef enum logic [0:0] {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

endpackage : acc_frame_gen_pkg
`default_nettype wire

// File: rtl/acc_frame_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_frame_gen_if
// Description : Sample-stream bus between a sample source, the framer and
//               the downstream accumulator. The framer takes the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_frame_gen_if
    import acc_frame_gen_pkg::*;
#(
    parameter int DIN_WIDTH       = c_DIN_WIDTH,
    parameter int LEN_WIDTH       = c_LEN_WIDTH,
    parameter int FRAME_CNT_WIDTH = c_FRAME_CNT_WIDTH
);
    // Upstream side: raw samples and framing controls
    logic [DIN_WIDTH-1:0]       din;
    logic                       din_valid;
    logic [LEN_WIDTH-1:0]       acc_len;
    logic                       sync_in;

    // Downstream side: framed stream towards the accumulator plus status
    logic [DIN_WIDTH-1:0]       dout;
    logic                       dout_valid;
    logic                       acc_done;
    logic                       frame_complete;
    logic [FRAME_CNT_WIDTH-1:0] frame_count;
    logic [LEN_WIDTH-1:0]       len_active;

    // Source / observer side
    modport master (
        output din, din_valid, acc_len, sync_in,
        input  dout, dout_valid, acc_done, frame_complete, frame_count, len_active
    );

    // Framer side
    modport slave (
        input  din, din_valid, acc_len, sync_in,
        output dout, dout_valid, acc_done, frame_complete, frame_count, len_active
    );

endinterface : acc_frame_gen_if
`default_nettype wire

// File: rtl/acc_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : acc_frame_gen
// Description : Frames a raw sample stream for the scalar accumulator. Passes
//               samples through with one cycle of latency, flags the first
//               sample of each acc_len-sample window with acc_done and marks
//               with frame_complete those dumps that close a full window.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_frame_gen
    import acc_frame_gen_pkg::*;
#(
    parameter int DIN_WIDTH       = c_DIN_WIDTH,
    parameter int LEN_WIDTH       = c_LEN_WIDTH,
    parameter int FRAME_CNT_WIDTH = c_FRAME_CNT_WIDTH
)(
    input  wire logic            clk,
    input  wire logic            rst,
    acc_frame_gen_if.slave       bus
);

    localparam logic [LEN_WIDTH-1:0]       c_LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_WIDTH-1:0] c_FC_ONE  = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                     r_state;
    logic [LEN_WIDTH-1:0]       r_cnt;
    logic [LEN_WIDTH-1:0]       r_len_active;
    logic [DIN_WIDTH-1:0]       r_dout;
    logic                       r_dout_valid;
    logic                       r_acc_done;
    logic                       r_frame_complete;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;

    logic [LEN_WIDTH-1:0]       w_len_next;
    logic                       w_window_full;
    logic                       w_boundary;
    logic                       w_full_close;

    // A zero length would never close a window, so it is promoted to one.
    assign w_len_next    = (bus.acc_len == '0) ? c_LEN_ONE : bus.acc_len;
    assign w_window_full = (r_cnt == r_len_active);
    // sync_in restarts framing even if the current window happens to be full.
    assign w_boundary    = (r_state == ARM) || bus.sync_in || w_window_full;
    // Only a natural close of a running window counts as a complete frame.
    assign w_full_close  = (r_state == RUN) && !bus.sync_in && w_window_full;

    // Input register stage, framing FSM, window counter and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ARM;
            r_cnt            <= '0;
            r_len_active     <= c_LEN_ONE;
            r_dout           <= '0;
            r_dout_valid     <= 1'b0;
            r_acc_done       <= 1'b0;
            r_frame_complete <= 1'b0;
            r_frame_count    <= '0;
        end else begin
            r_dout           <= bus.din;
            r_dout_valid     <= bus.din_valid;
            r_acc_done       <= 1'b0;
            r_frame_complete <= 1'b0;
            if (bus.din_valid) begin
                if (w_boundary) begin
                    r_acc_done   <= 1'b1;
                    r_cnt        <= c_LEN_ONE;
                    r_len_active <= w_len_next;
                    r_state      <= RUN;
                    if (w_full_close) begin
                        r_frame_complete <= 1'b1;
                        r_frame_count    <= r_frame_count + c_FC_ONE;
                    end
                end else begin
                    r_cnt <= r_cnt + c_LEN_ONE;
                end
            end else if (bus.sync_in) begin
                // Gaps freeze the count; a sync during a gap re-arms framing.
                r_state <= ARM;
            end
        end
    end

    assign bus.dout           = r_dout;
    assign bus.dout_valid     = r_dout_valid;
    assign bus.acc_done       = r_acc_done;
    assign bus.frame_complete = r_frame_complete;
    assign bus.frame_count    = r_frame_count;
    assign bus.len_active     = r_len_active;

endmodule : acc_frame_gen
`default_nettype wire

// File: tb/tb_acc_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_frame_gen
// Description : Self-checking bench for acc_frame_gen: directed scenarios
//               with literal expectations, then randomized traffic against a
//               queue-based window model, plus downstream window-sum checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_frame_gen;
    import acc_frame_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;

    acc_frame_gen_if #(.DIN_WIDTH(16), .LEN_WIDTH(16), .FRAME_CNT_WIDTH(32)) bus ();

    acc_frame_gen #(.DIN_WIDTH(16), .LEN_WIDTH(16), .FRAME_CNT_WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A window is a list of samples; it closes when it holds len samples.
    bit          m_ready = 1'b0;
    bit          m_open;
    int          m_len;
    int unsigned m_win[$];
    logic [15:0] e_dout;
    logic        e_dv, e_ad, e_fc;
    logic [31:0] e_count;
    logic [15:0] e_len;
    longint      e_sum;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            m_open  = 1'b0;
            m_len   = 1;
            m_win.delete();
            e_dout = 0; e_dv = 0; e_ad = 0; e_fc = 0; e_count = 0; e_len = 1;
        end else if (m_ready) begin
            e_dout = bus.din;
            e_dv   = bus.din_valid;
            e_ad   = 0;
            e_fc   = 0;
            if (bus.din_valid) begin
                bit full;
                full = m_open && (m_win.size() == m_len);
                if (!m_open || bus.sync_in || full) begin
                    e_ad = 1;
                    if (full && !bus.sync_in) begin
                        e_fc = 1;
                        e_count = e_count + 1;
                        e_sum = 0;
                        foreach (m_win[i]) e_sum += m_win[i];
                    end
                    m_win.delete();
                    m_win.push_back(bus.din);
                    m_len  = (bus.acc_len == 0) ? 1 : int'(bus.acc_len);
                    e_len  = 16'(m_len);
                    m_open = 1;
                end else begin
                    m_win.push_back(bus.din);
                end
            end else if (bus.sync_in) begin
                m_open = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    longint act_sum = 0;

    always @(negedge clk) begin
        if (m_ready) begin
            chk("dout",           bus.dout,           e_dout);
            chk("dout_valid",     bus.dout_valid,     e_dv);
            chk("acc_done",       bus.acc_done,       e_ad);
            chk("frame_complete", bus.frame_complete, e_fc);
            chk("frame_count",    bus.frame_count,    e_count);
            chk("len_active",     bus.len_active,     e_len);
            if (bus.dout_valid) begin
                if (bus.acc_done) begin
                    if (bus.frame_complete) chk("window_sum", act_sum, e_sum);
                    act_sum = bus.dout;
                end else begin
                    act_sum += bus.dout;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit v, input int d, input bit s);
        bus.din_valid = v;
        bus.din       = 16'(d);
        bus.sync_in   = s;
        tick();
        bus.din_valid = 1'b0;
        bus.sync_in   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.sync_in   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.din = '0; bus.din_valid = 1'b0; bus.sync_in = 1'b0; bus.acc_len = 16'd4;
        tick();
        rst = 1'b0;
        chk("reset_dout_valid", bus.dout_valid, 1'b0);
        chk("reset_len_active", bus.len_active, 16'd1);
        chk("reset_frame_count", bus.frame_count, 32'd0);

        // 1: len 4, 12 continuous samples -> two complete frames
        bus.acc_len = 16'd4;
        for (int i = 0; i < 12; i++) begin
            send(1'b1, i, 1'b0);
            if (i == 4) begin
                chk("t1_acc_done_s4", bus.acc_done, 1'b1);
                chk("t1_fc_s4", bus.frame_complete, 1'b1);
                chk("t1_dout_s4", bus.dout, 16'd4);
            end
        end
        chk("t1_frame_count", bus.frame_count, 32'd2);

        // 2: len 3 with gaps -> one complete frame at the 4th valid
        do_reset();
        bus.acc_len = 16'd3;
        begin
            bit pat [6] = '{1, 0, 1, 0, 1, 1};
            for (int i = 0; i < 6; i++) send(pat[i], 100 + i, 1'b0);
        end
        chk("t2_acc_done_4th", bus.acc_done, 1'b1);
        chk("t2_frame_count", bus.frame_count, 32'd1);

        // 3: length change mid-window applies from the next window
        do_reset();
        bus.acc_len = 16'd4;
        send(1'b1, 0, 1'b0);
        chk("t3_len_first", bus.len_active, 16'd4);
        bus.acc_len = 16'd2;
        for (int i = 1; i < 9; i++) begin
            send(1'b1, i, 1'b0);
            if (i == 4) chk("t3_len_switched", bus.len_active, 16'd2);
        end

        // 4: sync with 2nd sample restarts a len-5 window
        do_reset();
        bus.acc_len = 16'd5;
        send(1'b1, 1, 1'b0);
        send(1'b1, 2, 1'b1);
        chk("t4_sync_acc_done", bus.acc_done, 1'b1);
        chk("t4_sync_fc", bus.frame_complete, 1'b0);
        for (int i = 3; i <= 7; i++) send(1'b1, i, 1'b0);
        chk("t4_close_fc", bus.frame_complete, 1'b1);
        chk("t4_frame_count", bus.frame_count, 32'd1);

        // 5: len 0 behaves as len 1
        do_reset();
        bus.acc_len = 16'd0;
        for (int i = 0; i < 6; i++) send(1'b1, 7 * i, 1'b0);
        chk("t5_len_active", bus.len_active, 16'd1);
        chk("t5_frame_count", bus.frame_count, 32'd5);

        // 6: reset mid-window discards it
        do_reset();
        bus.acc_len = 16'd4;
        send(1'b1, 11, 1'b0);
        send(1'b1, 12, 1'b0);
        do_reset();
        chk("t6_rst_dout", bus.dout, 16'd0);
        chk("t6_rst_acc_done", bus.acc_done, 1'b0);
        send(1'b1, 13, 1'b0);
        chk("t6_acc_done", bus.acc_done, 1'b1);
        chk("t6_fc", bus.frame_complete, 1'b0);
        chk("t6_frame_count", bus.frame_count, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99) < 5) bus.acc_len = 16'($urandom_range(6));
            if ($urandom_range(999) < 4) begin
                do_reset();
            end else begin
                send($urandom_range(99) < 70, int'($urandom_range(65535)),
                     $urandom_range(99) < 3);
            end
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_acc_frame_gen
`default_nettype wire
